delta_dec_oned: RTL and testbench
=================================

Name: delta_dec_oned

Overview:
- Lane-wise delta decoder; the inverse of the team's 4-lane 16-bit vector subtractor used as a delta encoder (d[n] = x[n] - x[n-1]).
- Accepts a stream of packed difference vectors and rebuilds the original vectors by per-lane running accumulation: x[n] = x[n-1] + d[n], modulo 2^LW.
- Sits on the embedding/feature path between the delta-compressed buffer reader and the NLP compute lanes.
- Valid/ready on both sides; one registered pipeline stage.

Parameters:
- LANES, 4, number of independent lanes per vector.
- LW, 16, lane width in bits.
- FRAME_LEN, 8, vectors per frame; the first vector of each frame is absolute (not a delta). Legal range is 2..65535.
- DW is derived as LANES*LW (default 64). It is a localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  decoder can accept a beat.
- in_data  in  DW  packed deltas. Lane 0 is at [DW-1:DW-LW]; lane LANES-1 is at [LW-1:0].
- in_first  in  1  force this beat to be treated as an absolute frame start (resync).
- out_valid  out  1  reconstructed vector present.
- out_ready  in  1  downstream accepts.
- out_data  out  DW  reconstructed vector, same lane packing as in_data.
- out_last  out  1  marks the final vector of a frame.
- out_first  out  1  marks the first vector of a frame.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - out_valid=0, out_data=0, out_last=0, out_first=0.
  - Accumulator = 0 in every lane; beat counter = 0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-frame discards any held output and any partial frame. No beat is emitted.
- Handshake:
  - Input accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - in_ready = !out_valid | out_ready (combinational). No bubble under continuous flow, so throughput is 1 vector/clk.
  - Latency: a beat accepted at edge k appears on out_data with out_valid=1 after edge k, i.e. 1 cycle.
  - out_data, out_valid, out_last and out_first hold stable while out_valid=1 and out_ready=0.
  - in_data and in_first are ignored when no accept occurs.
- Beat counter (cnt, 0..FRAME_LEN-1):
  - A beat is a frame start if cnt==0 or in_first=1.
  - Frame start: each lane result r = in lane, i.e. an absolute value with no addition.
  - Otherwise: r = acc lane + in lane, truncated to LW bits. Wrap-around is intended (0xFFFF+0x0001=0x0000), so signed/unsigned interpretation does not matter.
  - On accept, acc <= r and out_data <= r.
  - out_first <= frame start.
  - out_last <= (effective index == FRAME_LEN-1). The effective index is 0 if in_first=1, else cnt.
  - cnt advances to effective index+1, wrapping to 0 after FRAME_LEN-1.
  - in_first=1 mid-frame restarts the frame: the beat becomes index 0 and the prior partial frame is abandoned without out_last.
  - in_first=1 when cnt==0 is the same as a normal frame start.
- Simultaneous output transfer and input accept in the same cycle: the new beat replaces the output register and out_valid stays 1.
- Output transfer with no accept: out_valid <= 0; out_data keeps its last value.
- Lanes are fully independent: no carry between lanes.
- When out_valid=0, out_last and out_first are don't-care but are driven 0 after reset.

Test Plan:
- Reset then one frame, FRAME_LEN=8, out_ready=1. Lane 0 gets deltas 0x0005 then 0x0001 x7, other lanes 0 → lane 0 outputs 0x0005,0x0006,…,0x000C, one per clk with 1-cycle latency. out_first on beat 0, out_last on beat 7.
- Wrap: frame start lane 3 = 0xFFFE, then deltas 0x0001, 0x0001, 0x0003 → 0xFFFE, 0xFFFF, 0x0000, 0x0003. No effect on lanes 0-2.
- Encoder round trip: random x[n] through the subtractor with x[n-1], frames of 8 → out_data == x[n] bit-exact over 1000 vectors, all 4 lanes.
- Backpressure: hold out_ready=0 for 5 cycles mid-frame → in_ready=0 from the cycle after the next accept, and out_data stable. Release → no beat lost or duplicated, sums still correct.
- Resync: assert in_first at beat 3 with in_data=0x1234 in all lanes → out_data=0x1234_1234_1234_1234 with out_first=1. No out_last for the abandoned frame; out_last appears 7 beats later.
- Reset mid-frame: rst_n=0 for 1 cycle while out_valid=1 and out_ready=0 → out_valid=0 next cycle. The next beat is treated as a frame start, with cnt restarted at 0.

Source files
------------

// File: rtl/delta_dec_oned.sv
// Lane-wise delta decoder: rebuilds vectors from per-lane differences by running
// accumulation mod 2^LW, restarting from an absolute vector at each frame start.
module delta_dec_oned #(
  parameter int LANES     = 4,
  parameter int LW        = 16,
  parameter int FRAME_LEN = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*LW-1:0]    in_data,
  input  logic                   in_first,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*LW-1:0]    out_data,
  output logic                   out_last,
  output logic                   out_first
);

  localparam int DW = LANES * LW;
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  // Handshake: a beat moves on a cycle where valid and ready are both high.
  // in_ready only needs the output slot to be empty or draining this cycle, so
  // the stage sustains one vector per clock; held outputs stay stable.
  logic          accept;
  logic          frame_start;
  logic [CW-1:0] cnt;
  logic [CW-1:0] eff_idx;
  logic [CW-1:0] next_cnt;
  logic [DW-1:0] result;

  assign in_ready    = !out_valid || out_ready;
  assign accept      = in_valid && in_ready;
  assign frame_start = in_first || (cnt == '0);
  assign eff_idx     = in_first ? '0 : cnt;
  assign next_cnt    = (eff_idx == LAST_IDX) ? '0 : eff_idx + CW'(1);

  // out_data always equals the accumulator, so it doubles as the running sum.
  always_comb begin
    result = '0;
    for (int i = 0; i < LANES; i++) begin
      if (frame_start)
        result[i*LW +: LW] = in_data[i*LW +: LW];
      else
        result[i*LW +: LW] = out_data[i*LW +: LW] + in_data[i*LW +: LW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_first <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_first <= frame_start;
      out_last  <= (eff_idx == LAST_IDX);
      cnt       <= next_cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_first <= 1'b0;
    end
  end

endmodule

// File: tb/tb_delta_dec_oned.sv
// Bench for delta_dec_oned: constant vector tables, an encoder-side reference
// driving deltas, and a scoreboard queue checked on every output transfer.
module tb_delta_dec_oned;

  localparam int LANES = 4;
  localparam int LW    = 16;
  localparam int FL    = 8;
  localparam int DW    = LANES * LW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_first;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_first;

  int check_cnt = 0;
  int fail_cnt  = 0;
  int ready_mode = 1;  // 0: hold low, 1: always high, 2: random

  logic [DW+1:0] exp_q[$];  // {data, first, last}

  logic [DW-1:0] enc_prev = '0;
  int            enc_cnt  = 0;

  typedef struct {
    logic [DW-1:0] din;
    logic          first;
    logic [DW-1:0] exp_data;
    logic          exp_first;
    logic          exp_last;
  } vec_t;
  vec_t tbl[16];

  delta_dec_oned #(.LANES(LANES), .LW(LW), .FRAME_LEN(FL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_first  (in_first),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_first (out_first)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // out_ready changes just after the rising edge only
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // scoreboard: pop and compare on every output transfer
  always @(negedge clk) begin
    logic [DW+1:0] e;
    if (rst_n && out_valid && out_ready) begin
      check_cnt++;
      if (exp_q.size() == 0) begin
        fail_cnt++;
        $display("FAIL out_unexpected: got data=%h first=%b last=%b, expected no beat",
                 out_data, out_first, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_data, out_first, out_last} !== e) begin
          fail_cnt++;
          $display("FAIL out_beat: got data=%h first=%b last=%b, expected data=%h first=%b last=%b",
                   out_data, out_first, out_last, e[DW+1:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    check_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // driver: call just after a rising edge; returns just after the accepting edge
  task automatic send_raw(input logic [DW-1:0] d, input logic f, input logic [DW+1:0] exp);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check_cnt++;
      fail_cnt++;
      $display("FAIL send_timeout: in_ready got 0 for %0d cycles, expected 1", waited);
      in_valid = 1'b0;
      in_first = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  // encoder reference: turns absolute vector x into the delta stream
  task automatic send_x(input logic [DW-1:0] x, input logic resync);
    logic [DW-1:0] d;
    logic          start;
    int            idx;
    start = resync || (enc_cnt == 0);
    idx   = resync ? 0 : enc_cnt;
    for (int i = 0; i < LANES; i++)
      d[i*LW +: LW] = start ? x[i*LW +: LW] : x[i*LW +: LW] - enc_prev[i*LW +: LW];
    send_raw(d, resync, {x, start, logic'(idx == FL - 1)});
    enc_prev = x;
    enc_cnt  = (idx == FL - 1) ? 0 : idx + 1;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_cnt++;
    if (exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL drain: got %0d beats outstanding, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready_mode(input int m);
    @(negedge clk);
    ready_mode = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] w_d[8];
    logic [15:0] w_e[8];
    logic [DW-1:0] xs;
    w_d = '{16'hFFFE, 16'h0001, 16'h0001, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    w_e = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0003, 16'h0003, 16'h0003, 16'h0003, 16'h0003};
    for (int i = 0; i < FL; i++) begin
      tbl[i].din       = (i == 0) ? 64'h0005_0000_0000_0000 : 64'h0001_0000_0000_0000;
      tbl[i].first     = 1'b0;
      tbl[i].exp_data  = {16'(5 + i), 48'h0};
      tbl[i].exp_first = (i == 0);
      tbl[i].exp_last  = (i == FL - 1);
      tbl[FL+i].din       = {48'h0, w_d[i]};
      tbl[FL+i].first     = 1'b0;
      tbl[FL+i].exp_data  = {48'h0, w_e[i]};
      tbl[FL+i].exp_first = (i == 0);
      tbl[FL+i].exp_last  = (i == FL - 1);
    end

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_first = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_out_valid", DW'(out_valid), '0);
    check("reset_out_data",  out_data,       '0);
    check("reset_out_first", DW'(out_first), '0);
    check("reset_out_last",  DW'(out_last),  '0);
    check("reset_in_ready",  DW'(in_ready),  DW'(1));
    @(posedge clk);
    #1;

    // ramp frame on lane 0, then wrap-around frame on lane 3
    for (int i = 0; i < 16; i++)
      send_raw(tbl[i].din, tbl[i].first, {tbl[i].exp_data, tbl[i].exp_first, tbl[i].exp_last});
    drain();

    // backpressure: stall output for 5 cycles mid-frame
    for (int i = 0; i < 3; i++) send_x({$urandom(), $urandom()}, 1'b0);
    set_ready_mode(0);
    xs = {$urandom(), $urandom()};
    send_x(xs, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready",  DW'(in_ready),  '0);
      check("bp_out_valid", DW'(out_valid), DW'(1));
      check("bp_out_data",  out_data,       xs);
    end
    set_ready_mode(1);
    for (int i = 0; i < 4; i++) send_x({$urandom(), $urandom()}, 1'b0);
    drain();

    // resync at beat 3 abandons the partial frame
    for (int i = 0; i < 3; i++) send_x({$urandom(), $urandom()}, 1'b0);
    send_x(64'h1234_1234_1234_1234, 1'b1);
    for (int i = 0; i < 7; i++) send_x({$urandom(), $urandom()}, 1'b0);
    drain();

    // reset mid-frame with a held output
    for (int i = 0; i < 2; i++) send_x({$urandom(), $urandom()}, 1'b0);
    set_ready_mode(0);
    send_x({$urandom(), $urandom()}, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    enc_cnt  = 0;
    enc_prev = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_out_valid", DW'(out_valid), '0);
    check("midreset_out_data",  out_data,       '0);
    set_ready_mode(1);
    for (int i = 0; i < FL; i++) send_x({$urandom(), $urandom()}, 1'b0);
    drain();

    // encoder round trip under random backpressure
    set_ready_mode(2);
    for (int i = 0; i < 1000; i++) send_x({$urandom(), $urandom()}, 1'b0);
    set_ready_mode(1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
    $finish;
  end

endmodule
